nor_chain_stim_gen: RTL

- Synchronous pulse-train generator that drives the input of the NOR/inverter delay chains under evaluation.
- Produces a programmable number of rectangular pulses with programmable high and low widths, counted in clock cycles.
- The generated edges are the stimulus for IDM delay and pulse-degradation characterisation.
- Sits directly upstream of the chain; its myout connects to the chain's myin.

---
 rtl/nor_chain_stim_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/nor_chain_stim_gen.sv
// nor_chain_stim_gen: pulse-train generator that feeds the NOR/inverter delay
// chain input. It emits num_pulses rectangular pulses. Each pulse is
// high_cycles clock cycles high, then low_cycles clock cycles low.
// All outputs are registered and lag the internal state by one edge, so a start
// accepted at edge k shows up as a rising myout at edge k+1.
// Optional build macro STIM_SWEEP_EN: after every pulse the latched high width
// shrinks by one cycle, down to a minimum of 1 cycle. This is used for
// pulse-degradation sweeps.
module nor_chain_stim_gen #(
  parameter int CNT_W = 8,
  parameter int NP_W  = 8
) (
  input  logic             myclk,
  input  logic             myrst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NP_W-1:0]  num_pulses,
  output logic             myout,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [NP_W-1:0]  pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phaseCnt_q, phaseCnt_d;
  logic [CNT_W-1:0] highLen_q, highLen_d;
  logic [CNT_W-1:0] lowLen_q, lowLen_d;
  logic [NP_W-1:0]  numLen_q, numLen_d;
  logic [NP_W-1:0]  pulseCnt_q, pulseCnt_d;
  logic             donePend_q, donePend_d;

  logic             myout_q, myout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfgErr_q, cfgErr_d;
  logic [NP_W-1:0]  pulseCntOut_q, pulseCntOut_d;

  logic             abortNow;
  logic             fieldsOk;
  logic [NP_W-1:0]  pulseInc;
  logic [CNT_W-1:0] highNext;

  // An abort only matters while a train is running. In IDLE it is ignored.
  assign abortNow = abort && (state_q != IDLE);
  assign fieldsOk = (high_cycles != '0) && (low_cycles != '0) && (num_pulses != '0);
  assign pulseInc = pulseCnt_q + 1'b1;

`ifdef STIM_SWEEP_EN
  localparam logic [CNT_W-1:0] SWEEP_MIN = CNT_W'(1);
  // Sweep mode narrows the next pulse by one cycle, but never below one cycle.
  assign highNext = (highLen_q > SWEEP_MIN) ? (highLen_q - 1'b1) : highLen_q;
`else
  // Without sweep, every pulse reuses the latched high width.
  assign highNext = highLen_q;
`endif

  // Next-state logic for the phase sequencer and the registered outputs.
  always_comb begin
    state_d       = state_q;
    phaseCnt_d    = phaseCnt_q;
    highLen_d     = highLen_q;
    lowLen_d      = lowLen_q;
    numLen_d      = numLen_q;
    pulseCnt_d    = pulseCnt_q;
    donePend_d    = 1'b0;
    cfgErr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (fieldsOk) begin
            highLen_d  = high_cycles;
            lowLen_d   = low_cycles;
            numLen_d   = num_pulses;
            pulseCnt_d = '0;
            phaseCnt_d = high_cycles - 1'b1;
            state_d    = HIGH;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abortNow) begin
          state_d = IDLE;
        end else if (phaseCnt_q == '0) begin
          phaseCnt_d = lowLen_q - 1'b1;
          highLen_d  = highNext;
          state_d    = LOW;
        end else begin
          phaseCnt_d = phaseCnt_q - 1'b1;
        end
      end
      LOW: begin
        if (abortNow) begin
          state_d = IDLE;
        end else if (phaseCnt_q == '0) begin
          pulseCnt_d = pulseInc;
          if (pulseInc == numLen_q) begin
            donePend_d = 1'b1;
            state_d    = IDLE;
          end else begin
            phaseCnt_d = highLen_q - 1'b1;
            state_d    = HIGH;
          end
        end else begin
          phaseCnt_d = phaseCnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    myout_d       = (state_q == HIGH) && !abortNow;
    busy_d        = (state_q != IDLE) && !abortNow;
    done_d        = donePend_q;
    pulseCntOut_d = pulseCnt_q;
  end

  // State and output registers. The synchronous active-low reset wins over everything.
  always_ff @(posedge myclk) begin
    if (!myrst_n) begin
      state_q       <= IDLE;
      phaseCnt_q    <= '0;
      highLen_q     <= '0;
      lowLen_q      <= '0;
      numLen_q      <= '0;
      pulseCnt_q    <= '0;
      donePend_q    <= 1'b0;
      myout_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfgErr_q      <= 1'b0;
      pulseCntOut_q <= '0;
    end else begin
      state_q       <= state_d;
      phaseCnt_q    <= phaseCnt_d;
      highLen_q     <= highLen_d;
      lowLen_q      <= lowLen_d;
      numLen_q      <= numLen_d;
      pulseCnt_q    <= pulseCnt_d;
      donePend_q    <= donePend_d;
      myout_q       <= myout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfgErr_q      <= cfgErr_d;
      pulseCntOut_q <= pulseCntOut_d;
    end
  end

  assign myout     = myout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfgErr_q;
  assign pulse_cnt = pulseCntOut_q;

endmodule
